gpio_serial_loader: RTL

GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

---
 rtl/gpio_serial_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gpio_serial_loader.sv
// Serial loader for the user pad control chain: fetches one config word per pad and shifts them out.
// Optional done interrupt (irq_o / irq_clr_i) is enabled by defining GPIO_LOADER_DONE_IRQ_EN.
module gpio_serial_loader #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned BITS     = 13,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic                                         wb_clk_i,
  input  logic                                         wb_rst_i,
  input  logic                                         start_i,
  output logic                                         busy_o,
  output logic [((NUM_PADS > 1) ? $clog2(NUM_PADS) : 1)-1:0] cfg_idx_o,
  input  logic [BITS-1:0]                              cfg_data_i,
  output logic                                         serial_clock,
  output logic                                         serial_data,
  output logic                                         serial_load,
  output logic                                         serial_resetn
`ifdef GPIO_LOADER_DONE_IRQ_EN
  ,
  input  logic                                         irq_clr_i,
  output logic                                         irq_o
`endif
);

  localparam int unsigned IdxW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int unsigned BitW = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StShiftLo = 3'd2;
  localparam logic [2:0] StShiftHi = 3'd3;
  localparam logic [2:0] StLoad    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] pad_q, pad_d;
  logic [IdxW-1:0] cfg_idx_q, cfg_idx_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [7:0]      div_q, div_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            busy_q, busy_d;
  logic            sclk_q, sclk_d;
  logic            sdata_q, sdata_d;
  logic            sload_q, sload_d;
  logic            resetn_q;
  logic            div_last;

  assign div_last = (div_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    pad_d     = pad_q;
    cfg_idx_d = cfg_idx_q;
    bit_d     = bit_q;
    div_d     = div_q;
    shift_d   = shift_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          pad_d     = IdxW'(NUM_PADS - 1);
          cfg_idx_d = IdxW'(NUM_PADS - 1);
          state_d   = StFetch;
        end
      end
      StFetch: begin
        shift_d = cfg_data_i;
        bit_d   = BitW'(BITS - 1);
        div_d   = 8'd0;
        state_d = StShiftLo;
      end
      StShiftLo: begin
        if (div_last) begin
          div_d   = 8'd0;
          state_d = StShiftHi;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShiftHi: begin
        if (div_last) begin
          div_d   = 8'd0;
          shift_d = shift_q << 1;
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            state_d = StShiftLo;
          end else if (pad_q != '0) begin
            pad_d     = pad_q - 1'b1;
            cfg_idx_d = pad_q - 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StLoad;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StLoad: begin
        if (div_last) begin
          div_d   = 8'd0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so the pins come straight off flops.
  always_comb begin
    busy_d  = (state_d != StIdle);
    sclk_d  = (state_d == StShiftHi);
    sload_d = (state_d == StLoad);
    sdata_d = 1'b0;
    if (state_d == StShiftLo || state_d == StShiftHi) begin
      sdata_d = shift_d[BITS-1];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      pad_q     <= '0;
      cfg_idx_q <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sload_q   <= 1'b0;
      resetn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pad_q     <= pad_d;
      cfg_idx_q <= cfg_idx_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      sload_q   <= sload_d;
      resetn_q  <= 1'b1;
    end
  end

  assign busy_o        = busy_q;
  assign cfg_idx_o     = cfg_idx_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdata_q;
  assign serial_load   = sload_q;
  assign serial_resetn = resetn_q;

`ifdef GPIO_LOADER_DONE_IRQ_EN
  // done_q marks the first idle cycle after a load; irq follows one cycle later.
  logic done_q;
  logic irq_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= (state_q == StLoad) && div_last;
      if (done_q) begin
        irq_q <= 1'b1;
      end else if (irq_clr_i) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign irq_o = irq_q;
`endif

endmodule
